pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Receive-side counterpart of the team's PWM generator.
- Samples an incoming PWM line and measures high time and period in generator "ticks".
- Reports the recovered duty value (0..128) and, in servo mode, the recovered 4-bit servo command (0..15).
- Used for loopback self-test and for decoding external PWM/servo inputs.

Parameters:
- DVSR_FAST, 10416, prescaler terminal count when sel=0; tick period = DVSR_FAST+1 clocks.
- DVSR_SERVO, 200000, prescaler terminal count when sel=1; tick period = DVSR_SERVO+1 clocks.
- TIMEOUT_TICKS, 255, ticks without an edge before the signal is declared lost (max 255).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-high.
- ena  input  1  block enable; low forces IDLE.
- sel  input  1  mode: 0 = fast PWM (duty 0..128), 1 = servo (pulse 5..10 ticks).
- pwm_in  input  1  asynchronous PWM line.
- duty_o  output  8  last measured high time in ticks, saturating at 255.
- period_o  output  8  last measured period in ticks, saturating at 255.
- servo_o  output  4  recovered servo command; 0 when sel=0.
- valid_o  output  1  one-cycle strobe when duty_o/period_o/servo_o update.
- lost_o  output  1  high while no edge has been seen for TIMEOUT_TICKS.

Behaviour:
- Reset (rst_n=1, asynchronous): all outputs 0, state IDLE, all counters 0, synchronizer flops 0.
- Input path: pwm_in passes through a 2-FF synchronizer, then a registered copy for edge detection.
  - rise = s & ~s_d; fall = ~s & s_d.
  - Edge-to-state latency is 3 clk.
- Prescaler: 32-bit counter q.
  - tick asserts when q == DVSR (mode-selected); q then wraps to 0.
  - On every rise, q loads DVSR>>1 (half-tick phase alignment), so a high time of N ticks measures exactly N.
- Counters: hi_cnt and lo_cnt, 8-bit, saturating at 255, increment on tick in HIGH and LOW respectively. idle_cnt, 8-bit, increments on tick and clears on any edge.
- States:
  - IDLE: entered on reset or ena=0. Outputs hold. Go to SYNC when ena=1.
  - SYNC: waits for the first rise, ignoring any fall. On rise: clear counters, go HIGH. No valid_o is produced from a partial period.
  - HIGH: count hi_cnt. On fall go LOW.
  - LOW: count lo_cnt. On rise:
    - duty_o <= hi_cnt; period_o <= sat255(hi_cnt+lo_cnt).
    - servo_o updated; valid_o=1 for one cycle; lost_o <= 0.
    - Clear counters, go HIGH.
- Servo mapping (sel=1): servo_o = clamp((hi_cnt-5)*3, 0, 15), computed at 8+ bits.
  - hi_cnt ≤ 5 gives 0; hi_cnt ≥ 10 gives 15.
  - When sel=0, servo_o = 0.
- Timeout: in SYNC, HIGH or LOW, if idle_cnt reaches TIMEOUT_TICKS:
  - lost_o <= 1; duty_o <= (s ? 128 : 0); period_o <= 0; servo_o <= 0.
  - valid_o pulses once; go SYNC.
  - No further valid_o until a full period has been measured.
- sel change (sel != registered sel) in any non-IDLE state: abort to SYNC, clear counters, no valid_o. Outputs hold their values.
- Rise and tick in the same cycle: the edge takes priority; the tick is not counted.
- ena deasserted mid-measurement: go IDLE immediately; the partial measurement is discarded.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
- PWM_GLITCH_FILTER_EN.
- When defined: a 3-sample filter sits after the synchronizer. The filtered level changes only when 3 consecutive samples agree, so pulses of 1–2 clk are rejected. Edge latency grows from 3 to 5 clk.
- When undefined: no filter; every synchronized transition is an edge.

Test Plan:
- Bench override: DVSR_FAST=9, DVSR_SERVO=19, TIMEOUT_TICKS=255.
- Reset: assert rst_n with pwm_in toggling -> all outputs 0; no valid_o for 2 periods after release until the first full period completes.
- Fast mode, sel=0, ena=1: pwm_in high 40×10 clk, low 88×10 clk, repeated -> first valid_o at the end of period 2 with duty_o=40, period_o=128, servo_o=0; valid_o every 1280 clk thereafter.
- Servo mode, sel=1: high 7×20 clk, low 121×20 clk -> duty_o=7, servo_o=6. Repeat with high 3 ticks -> servo_o=0; with high 12 ticks -> servo_o=15.
- Boundaries: duty 0 (line held low) -> after 255 ticks lost_o=1, duty_o=0, one valid_o. Line held high -> lost_o=1, duty_o=128. Resuming a 64/128 waveform -> lost_o=0, duty_o=64.
- Abort: toggle sel mid-HIGH -> no valid_o for that period, outputs unchanged, re-lock on the following full period. ena=0 mid-LOW -> IDLE, outputs held.
- PWM_GLITCH_FILTER_EN defined: inject 2-clk low glitch inside a 40-tick high pulse -> duty_o=40. Undefined: the same stimulus produces a spurious short measurement.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an incoming PWM line in generator ticks.
// Define PWM_GLITCH_FILTER_EN to add a 3-sample glitch filter after the synchronizer.
module pwm_capture #(
  parameter int unsigned DVSR_FAST     = 10416,
  parameter int unsigned DVSR_SERVO    = 200000,
  parameter int unsigned TIMEOUT_TICKS = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       sel,
  input  logic       pwm_in,
  output logic [7:0] duty_o,
  output logic [7:0] period_o,
  output logic [3:0] servo_o,
  output logic       valid_o,
  output logic       lost_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SYNC = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] LOW  = 2'd3;

  localparam logic [31:0] DvsrFast   = 32'(DVSR_FAST);
  localparam logic [31:0] DvsrServo  = 32'(DVSR_SERVO);
  localparam logic [7:0]  TimeoutM1  = 8'(TIMEOUT_TICKS - 1);

  logic [1:0]  state_q, state_d;
  logic        sync1_q, sync2_q, prev_q;
  logic        selQ_q;
  logic [31:0] presc_q, presc_d;
  logic [7:0]  hiCnt_q, hiCnt_d, loCnt_q, loCnt_d, idleCnt_q, idleCnt_d;
  logic [7:0]  duty_q, duty_d, period_q, period_d;
  logic [3:0]  servo_q, servo_d;
  logic        valid_q, valid_d, lost_q, lost_d;

  logic        sLvl, rise, fall, tick, selChange, timeoutHit;
  logic [31:0] dvsr;
  logic [8:0]  sumHiLo;
  logic [9:0]  servoProd;
  logic [3:0]  servoCalc;

  function automatic logic [7:0] satInc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef PWM_GLITCH_FILTER_EN
  // Level only moves once three consecutive synchronized samples agree; prev_q doubles as the held level.
  logic [1:0] samp_q;
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) samp_q <= 2'b00;
    else       samp_q <= {samp_q[0], sync2_q};
  end
  always_comb begin
    sLvl = prev_q;
    if (sync2_q & samp_q[0] & samp_q[1])          sLvl = 1'b1;
    else if (~(sync2_q | samp_q[0] | samp_q[1]))  sLvl = 1'b0;
  end
`else
  assign sLvl = sync2_q;
`endif

  assign rise      = sLvl & ~prev_q;
  assign fall      = ~sLvl & prev_q;
  assign dvsr      = selQ_q ? DvsrServo : DvsrFast;
  assign tick      = (presc_q == dvsr);
  assign selChange = (sel != selQ_q);
  assign timeoutHit = tick && (idleCnt_q == TimeoutM1) && !(rise || fall);

  // Reloading half a tick on each rise centres tick sampling inside the pulse.
  always_comb begin
    presc_d = presc_q + 32'd1;
    if (selChange)  presc_d = 32'd0;
    else if (rise)  presc_d = dvsr >> 1;
    else if (tick)  presc_d = 32'd0;
  end

  always_comb begin
    sumHiLo   = {1'b0, hiCnt_q} + {1'b0, loCnt_q};
    servoProd = 10'd0;
    servoCalc = 4'd0;
    if (hiCnt_q > 8'd5) begin
      servoProd = ({2'b00, hiCnt_q} - 10'd5) * 10'd3;
      servoCalc = (servoProd > 10'd15) ? 4'd15 : servoProd[3:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    hiCnt_d   = hiCnt_q;
    loCnt_d   = loCnt_q;
    idleCnt_d = idleCnt_q;
    duty_d    = duty_q;
    period_d  = period_q;
    servo_d   = servo_q;
    valid_d   = 1'b0;
    lost_d    = lost_q;
    if (!ena) begin
      state_d   = IDLE;
      hiCnt_d   = 8'd0;
      loCnt_d   = 8'd0;
      idleCnt_d = 8'd0;
    end else if (state_q == IDLE) begin
      state_d = SYNC;
    end else if (selChange) begin
      state_d   = SYNC;
      hiCnt_d   = 8'd0;
      loCnt_d   = 8'd0;
      idleCnt_d = 8'd0;
    end else begin
      if (rise || fall) idleCnt_d = 8'd0;
      else if (tick)    idleCnt_d = satInc(idleCnt_q);
      case (state_q)
        SYNC: if (rise) begin
          hiCnt_d = 8'd0;
          loCnt_d = 8'd0;
          state_d = HIGH;
        end
        HIGH: begin
          if (fall)      state_d = LOW;
          else if (tick) hiCnt_d = satInc(hiCnt_q);
        end
        LOW: begin
          if (rise) begin
            duty_d   = hiCnt_q;
            period_d = sumHiLo[8] ? 8'hFF : sumHiLo[7:0];
            servo_d  = selQ_q ? servoCalc : 4'd0;
            valid_d  = 1'b1;
            lost_d   = 1'b0;
            hiCnt_d  = 8'd0;
            loCnt_d  = 8'd0;
            state_d  = HIGH;
          end else if (tick) begin
            loCnt_d = satInc(loCnt_q);
          end
        end
        default: state_d = IDLE;
      endcase
      // idleCnt keeps climbing past the threshold so the loss strobe fires only once per silence.
      if (timeoutHit) begin
        lost_d   = 1'b1;
        duty_d   = sLvl ? 8'd128 : 8'd0;
        period_d = 8'd0;
        servo_d  = 4'd0;
        valid_d  = 1'b1;
        hiCnt_d  = 8'd0;
        loCnt_d  = 8'd0;
        state_d  = SYNC;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      selQ_q    <= 1'b0;
      presc_q   <= 32'd0;
      hiCnt_q   <= 8'd0;
      loCnt_q   <= 8'd0;
      idleCnt_q <= 8'd0;
      duty_q    <= 8'd0;
      period_q  <= 8'd0;
      servo_q   <= 4'd0;
      valid_q   <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= pwm_in;
      sync2_q   <= sync1_q;
      prev_q    <= sLvl;
      selQ_q    <= sel;
      presc_q   <= presc_d;
      hiCnt_q   <= hiCnt_d;
      loCnt_q   <= loCnt_d;
      idleCnt_q <= idleCnt_d;
      duty_q    <= duty_d;
      period_q  <= period_d;
      servo_q   <= servo_d;
      valid_q   <= valid_d;
      lost_q    <= lost_d;
    end
  end

  assign duty_o   = duty_q;
  assign period_o = period_q;
  assign servo_o  = servo_q;
  assign valid_o  = valid_q;
  assign lost_o   = lost_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed self-checking bench for pwm_capture with tick periods of 10 (fast) and 20 (servo) clocks.
// Expectations for the glitch scenario follow PWM_GLITCH_FILTER_EN.
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       sel = 1'b0;
  logic       pwm_in = 1'b0;
  logic [7:0] duty_o, period_o;
  logic [3:0] servo_o;
  logic       valid_o, lost_o;

  int    checkCount = 0;
  int    passCount = 0;
  int    validCount = 0;
  longint cycleCnt = 0;
  longint lastValidCyc = 0;
  longint prevValidCyc = 0;

  pwm_capture #(
    .DVSR_FAST(9),
    .DVSR_SERVO(19),
    .TIMEOUT_TICKS(255)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .sel(sel),
    .pwm_in(pwm_in),
    .duty_o(duty_o),
    .period_o(period_o),
    .servo_o(servo_o),
    .valid_o(valid_o),
    .lost_o(lost_o)
  );

  always #5 clk = ~clk;

  // Counts valid strobes and remembers when the last two occurred.
  always @(negedge clk) begin
    cycleCnt++;
    if (valid_o) begin
      validCount++;
      prevValidCyc = lastValidCyc;
      lastValidCyc = cycleCnt;
    end
  end

  task automatic waitClocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drivePeriod(input int hiTicks, input int loTicks, input int tickClk);
    pwm_in = 1'b1;
    waitClocks(hiTicks * tickClk);
    pwm_in = 1'b0;
    waitClocks(loTicks * tickClk);
  endtask

  task automatic waitValid(input int base, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (validCount > base) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    ena = 1'b1;
    sel = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pwm_in = ~pwm_in;
      waitClocks(3);
    end
    checkCount++; if (duty_o !== 8'd0) $display("[TB] FAIL reset_duty got=%0d exp=0", duty_o); else passCount++;
    checkCount++; if (period_o !== 8'd0) $display("[TB] FAIL reset_period got=%0d exp=0", period_o); else passCount++;
    checkCount++; if (servo_o !== 4'd0) $display("[TB] FAIL reset_servo got=%0d exp=0", servo_o); else passCount++;
    checkCount++; if (valid_o !== 1'b0) $display("[TB] FAIL reset_valid got=%0b exp=0", valid_o); else passCount++;
    checkCount++; if (lost_o !== 1'b0) $display("[TB] FAIL reset_lost got=%0b exp=0", lost_o); else passCount++;
    pwm_in = 1'b0;
    waitClocks(5);
    rst_n = 1'b0;
    waitClocks(10);
    drivePeriod(40, 88, 10);
    checkCount++; if (validCount !== 0) $display("[TB] FAIL reset_no_partial valid count got=%0d exp=0", validCount); else passCount++;
  endtask

  task automatic test_fast_mode;
    drivePeriod(40, 88, 10);
    checkCount++; if (validCount !== 1) $display("[TB] FAIL fast_first_valid count got=%0d exp=1", validCount); else passCount++;
    checkCount++; if (duty_o !== 8'd40) $display("[TB] FAIL fast_duty got=%0d exp=40", duty_o); else passCount++;
    checkCount++; if (period_o !== 8'd128) $display("[TB] FAIL fast_period got=%0d exp=128", period_o); else passCount++;
    checkCount++; if (servo_o !== 4'd0) $display("[TB] FAIL fast_servo got=%0d exp=0", servo_o); else passCount++;
    checkCount++; if (lost_o !== 1'b0) $display("[TB] FAIL fast_lost got=%0b exp=0", lost_o); else passCount++;
    drivePeriod(40, 88, 10);
    checkCount++; if (validCount !== 2) $display("[TB] FAIL fast_second_valid count got=%0d exp=2", validCount); else passCount++;
    checkCount++; if (lastValidCyc - prevValidCyc !== 64'sd1280) $display("[TB] FAIL fast_interval got=%0d exp=1280", lastValidCyc - prevValidCyc); else passCount++;
  endtask

  task automatic test_servo_mode;
    int base;
    base = validCount;
    sel = 1'b1;
    drivePeriod(7, 121, 20);
    drivePeriod(7, 121, 20);
    checkCount++; if (validCount !== base + 1) $display("[TB] FAIL servo_count got=%0d exp=%0d", validCount, base + 1); else passCount++;
    checkCount++; if (duty_o !== 8'd7) $display("[TB] FAIL servo7_duty got=%0d exp=7", duty_o); else passCount++;
    checkCount++; if (period_o !== 8'd128) $display("[TB] FAIL servo7_period got=%0d exp=128", period_o); else passCount++;
    checkCount++; if (servo_o !== 4'd6) $display("[TB] FAIL servo7_cmd got=%0d exp=6", servo_o); else passCount++;
    drivePeriod(3, 121, 20);
    drivePeriod(12, 121, 20);
    checkCount++; if (duty_o !== 8'd3) $display("[TB] FAIL servo3_duty got=%0d exp=3", duty_o); else passCount++;
    checkCount++; if (period_o !== 8'd124) $display("[TB] FAIL servo3_period got=%0d exp=124", period_o); else passCount++;
    checkCount++; if (servo_o !== 4'd0) $display("[TB] FAIL servo3_cmd got=%0d exp=0", servo_o); else passCount++;
    drivePeriod(7, 121, 20);
    checkCount++; if (duty_o !== 8'd12) $display("[TB] FAIL servo12_duty got=%0d exp=12", duty_o); else passCount++;
    checkCount++; if (period_o !== 8'd133) $display("[TB] FAIL servo12_period got=%0d exp=133", period_o); else passCount++;
    checkCount++; if (servo_o !== 4'd15) $display("[TB] FAIL servo12_cmd got=%0d exp=15", servo_o); else passCount++;
    checkCount++; if (validCount !== base + 4) $display("[TB] FAIL servo_total_count got=%0d exp=%0d", validCount, base + 4); else passCount++;
  endtask

  task automatic test_lost_low;
    int base;
    bit got;
    base = validCount;
    sel = 1'b0;
    waitValid(base, 3000, got);
    checkCount++; if (got !== 1'b1) $display("[TB] FAIL lost_low_timeout got=no_valid exp=valid within 3000 clk"); else passCount++;
    waitClocks(5);
    checkCount++; if (lost_o !== 1'b1) $display("[TB] FAIL lost_low_flag got=%0b exp=1", lost_o); else passCount++;
    checkCount++; if (duty_o !== 8'd0) $display("[TB] FAIL lost_low_duty got=%0d exp=0", duty_o); else passCount++;
    checkCount++; if (period_o !== 8'd0) $display("[TB] FAIL lost_low_period got=%0d exp=0", period_o); else passCount++;
    checkCount++; if (servo_o !== 4'd0) $display("[TB] FAIL lost_low_servo got=%0d exp=0", servo_o); else passCount++;
    waitClocks(2800);
    checkCount++; if (validCount !== base + 1) $display("[TB] FAIL lost_low_single count got=%0d exp=%0d", validCount, base + 1); else passCount++;
  endtask

  task automatic test_lost_high_resume;
    int base;
    bit got;
    base = validCount;
    pwm_in = 1'b1;
    waitValid(base, 3000, got);
    checkCount++; if (got !== 1'b1) $display("[TB] FAIL lost_high_timeout got=no_valid exp=valid within 3000 clk"); else passCount++;
    waitClocks(5);
    checkCount++; if (lost_o !== 1'b1) $display("[TB] FAIL lost_high_flag got=%0b exp=1", lost_o); else passCount++;
    checkCount++; if (duty_o !== 8'd128) $display("[TB] FAIL lost_high_duty got=%0d exp=128", duty_o); else passCount++;
    drivePeriod(64, 64, 10);
    drivePeriod(64, 64, 10);
    drivePeriod(64, 64, 10);
    checkCount++; if (lost_o !== 1'b0) $display("[TB] FAIL resume_lost got=%0b exp=0", lost_o); else passCount++;
    checkCount++; if (duty_o !== 8'd64) $display("[TB] FAIL resume_duty got=%0d exp=64", duty_o); else passCount++;
    checkCount++; if (period_o !== 8'd128) $display("[TB] FAIL resume_period got=%0d exp=128", period_o); else passCount++;
    checkCount++; if (validCount !== base + 2) $display("[TB] FAIL resume_count got=%0d exp=%0d", validCount, base + 2); else passCount++;
  endtask

  task automatic test_abort_sel;
    int base;
    base = validCount;
    pwm_in = 1'b1;
    waitClocks(200);
    sel = 1'b1;
    waitClocks(5);
    sel = 1'b0;
    waitClocks(195);
    pwm_in = 1'b0;
    waitClocks(880);
    checkCount++; if (validCount !== base + 1) $display("[TB] FAIL abort_sel_count got=%0d exp=%0d", validCount, base + 1); else passCount++;
    drivePeriod(40, 88, 10);
    checkCount++; if (validCount !== base + 1) $display("[TB] FAIL abort_sel_nolock count got=%0d exp=%0d", validCount, base + 1); else passCount++;
    checkCount++; if (duty_o !== 8'd64) $display("[TB] FAIL abort_sel_hold_duty got=%0d exp=64", duty_o); else passCount++;
    drivePeriod(40, 88, 10);
    checkCount++; if (validCount !== base + 2) $display("[TB] FAIL abort_sel_relock count got=%0d exp=%0d", validCount, base + 2); else passCount++;
    checkCount++; if (duty_o !== 8'd40) $display("[TB] FAIL abort_sel_relock_duty got=%0d exp=40", duty_o); else passCount++;
  endtask

  task automatic test_abort_ena;
    int base;
    base = validCount;
    ena = 1'b0;
    drivePeriod(10, 10, 10);
    drivePeriod(10, 10, 10);
    checkCount++; if (validCount !== base) $display("[TB] FAIL ena_idle_count got=%0d exp=%0d", validCount, base); else passCount++;
    checkCount++; if (duty_o !== 8'd40) $display("[TB] FAIL ena_hold_duty got=%0d exp=40", duty_o); else passCount++;
    checkCount++; if (period_o !== 8'd128) $display("[TB] FAIL ena_hold_period got=%0d exp=128", period_o); else passCount++;
    ena = 1'b1;
    drivePeriod(20, 108, 10);
    drivePeriod(20, 108, 10);
    checkCount++; if (validCount !== base + 1) $display("[TB] FAIL ena_relock_count got=%0d exp=%0d", validCount, base + 1); else passCount++;
    checkCount++; if (duty_o !== 8'd20) $display("[TB] FAIL ena_relock_duty got=%0d exp=20", duty_o); else passCount++;
  endtask

  task automatic test_glitch;
    int base;
    base = validCount;
    pwm_in = 1'b1;
    waitClocks(200);
    pwm_in = 1'b0;
    waitClocks(2);
    pwm_in = 1'b1;
    waitClocks(198);
    pwm_in = 1'b0;
    waitClocks(880);
    pwm_in = 1'b1;
    waitClocks(10);
`ifdef PWM_GLITCH_FILTER_EN
    checkCount++; if (validCount !== base + 2) $display("[TB] FAIL glitch_count got=%0d exp=%0d", validCount, base + 2); else passCount++;
    checkCount++; if (duty_o !== 8'd40) $display("[TB] FAIL glitch_duty got=%0d exp=40", duty_o); else passCount++;
    checkCount++; if (period_o !== 8'd128) $display("[TB] FAIL glitch_period got=%0d exp=128", period_o); else passCount++;
`else
    checkCount++; if (validCount !== base + 3) $display("[TB] FAIL glitch_count got=%0d exp=%0d", validCount, base + 3); else passCount++;
    checkCount++; if (duty_o !== 8'd20) $display("[TB] FAIL glitch_duty got=%0d exp=20", duty_o); else passCount++;
    checkCount++; if (period_o !== 8'd108) $display("[TB] FAIL glitch_period got=%0d exp=108", period_o); else passCount++;
`endif
  endtask

  initial begin
    #2;
    test_reset;
    test_fast_mode;
    test_servo_mode;
    test_lost_low;
    test_lost_high_resume;
    test_abort_sel;
    test_abort_ena;
    test_glitch;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout exp=bench completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
